// File: rtl/zone_demux_seq.sv
// zone_demux_seq: registered 1xN irrigation-zone demultiplexer with break-before-make
// and an auto-sequencing mode. At most one valve output is ever high.
//
// Ports:
//   clk_i          system clock, rising edge
//   reset_i        asynchronous active-high reset (internally released synchronously)
//   in_i           global enable; 0 closes all valves and freezes auto timing
//   mode_i         0 = manual (sel_i), 1 = auto sequence
//   sel_i          manual zone code, 1..N; 0 or >N selects no zone
//   start_i        auto: begin a sequence (accepted only when idle, mode_i=1, in_i=1)
//   dwell_i        cycles per zone, latched at start; 0 is treated as 1
//   zone_mask_i    auto: 1 = zone included; latched at start
//   out_o          one-hot/zero valve enables (registered)
//   active_zone_o  code 1..N of the zone on out_o, 0 if none (registered)
//   busy_o         auto sequence in progress
//   done_o         one-cycle pulse at the end of a complete auto sequence
module zone_demux_seq #(
    parameter int unsigned N       = 7,
    parameter int unsigned SEL_W   = 3,
    parameter int unsigned DWELL_W = 16,
    parameter int unsigned GAP     = 2
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               in_i,
    input  logic               mode_i,
    input  logic [SEL_W-1:0]   sel_i,
    input  logic               start_i,
    input  logic [DWELL_W-1:0] dwell_i,
    input  logic [N-1:0]       zone_mask_i,
    output logic [N-1:0]       out_o,
    output logic [SEL_W-1:0]   active_zone_o,
    output logic               busy_o,
    output logic               done_o
);

    localparam int unsigned     GapW    = $clog2(GAP + 1);
    // Entering a gap from an open zone: this edge already produces the first closed cycle.
    localparam logic [GapW-1:0] GapLoad = GapW'(GAP - 1);
    // Pausing on in_i=0: the paused cycles do not count, all GAP closed cycles follow resume.
    localparam logic [GapW-1:0] GapFull = GapW'(GAP);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGap  = 2'd1;
    localparam logic [1:0] StOn   = 2'd2;
    localparam logic [1:0] StFin  = 2'd3;

    // Reset synchroniser: asserts immediately, releases two clock edges later.
    logic [1:0] rst_sync_q;
    logic       rst_int;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) rst_sync_q <= 2'b11;
        else         rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst_int = rst_sync_q[1];

    logic [1:0]         state_q, state_d;
    logic [SEL_W-1:0]   zone_q, zone_d;        // index 0..N-1 of the current/pending zone
    logic [SEL_W-1:0]   gtgt_q, gtgt_d;        // manual gap destination code
    logic [GapW-1:0]    gap_q, gap_d;
    logic [DWELL_W-1:0] dwell_left_q, dwell_left_d;
    logic [DWELL_W-1:0] dwell_lat_q, dwell_lat_d;
    logic [N-1:0]       mask_q, mask_d;
    logic               busy_q, busy_d;
    logic [N-1:0]       out_q, out_d;
    logic [SEL_W-1:0]   az_q, az_d;
    logic               done_q, done_d;

    logic [SEL_W-1:0]   target;
    logic [DWELL_W-1:0] dwell_eff;
    logic [SEL_W-1:0]   first_idx, next_idx;
    logic               first_vld, next_vld;

    always_comb begin
        target = '0;
        if (in_i && (sel_i != '0) && (int'(sel_i) <= int'(N))) target = sel_i;
    end

    assign dwell_eff = (dwell_i == '0) ? DWELL_W'(1) : dwell_i;

    // Lowest enabled zone at start, and lowest latched zone above the current one.
    always_comb begin
        first_vld = 1'b0;
        first_idx = '0;
        next_vld  = 1'b0;
        next_idx  = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (zone_mask_i[i]) begin
                first_vld = 1'b1;
                first_idx = SEL_W'(i);
            end
            if (mask_q[i] && (i > int'(zone_q))) begin
                next_vld = 1'b1;
                next_idx = SEL_W'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        zone_d       = zone_q;
        gtgt_d       = gtgt_q;
        gap_d        = gap_q;
        dwell_left_d = dwell_left_q;
        dwell_lat_d  = dwell_lat_q;
        mask_d       = mask_q;
        busy_d       = busy_q;
        if (!mode_i) begin
            if (busy_q) begin
                // Abort the sequence, then break-before-make into the manual target.
                busy_d  = 1'b0;
                state_d = StGap;
                gtgt_d  = target;
                gap_d   = GapLoad;
            end else begin
                case (state_q)
                    StOn: begin
                        if (target == '0) begin
                            state_d = StIdle;
                        end else if (target != zone_q + SEL_W'(1)) begin
                            state_d = StGap;
                            gtgt_d  = target;
                            gap_d   = GapLoad;
                        end
                    end
                    StGap: begin
                        if (target == '0) begin
                            state_d = StIdle;
                        end else if (target != gtgt_q) begin
                            gtgt_d = target;
                            gap_d  = GapLoad;
                        end else if (gap_q == '0) begin
                            state_d = StOn;
                            zone_d  = target - SEL_W'(1);
                        end else begin
                            gap_d = gap_q - GapW'(1);
                        end
                    end
                    default: begin
                        state_d = StIdle;
                        if (target != '0) begin
                            state_d = StOn;
                            zone_d  = target - SEL_W'(1);
                        end
                    end
                endcase
            end
        end else if (!busy_q) begin
            // Auto mode, not sequencing: anything left open from manual closes.
            state_d = StIdle;
            if ((state_q == StIdle) && start_i && in_i) begin
                mask_d      = zone_mask_i;
                dwell_lat_d = dwell_eff;
                if (first_vld) begin
                    state_d      = StOn;
                    zone_d       = first_idx;
                    dwell_left_d = dwell_eff;
                    busy_d       = 1'b1;
                end else begin
                    state_d = StFin;
                end
            end
        end else begin
            case (state_q)
                StOn: begin
                    if (dwell_left_q <= DWELL_W'(1)) begin
                        if (next_vld) begin
                            state_d      = StGap;
                            zone_d       = next_idx;
                            dwell_left_d = dwell_lat_q;
                            gap_d        = GapLoad;
                        end else begin
                            state_d = StFin;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        dwell_left_d = dwell_left_q - DWELL_W'(1);
                        if (!in_i) begin
                            state_d = StGap;
                            gap_d   = GapFull;
                        end
                    end
                end
                StGap: begin
                    if (in_i) begin
                        if (gap_q == '0) state_d = StOn;
                        else             gap_d   = gap_q - GapW'(1);
                    end
                end
                default: begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // Outputs are registered copies of what the next state implies.
    always_comb begin
        out_d = '0;
        for (int i = 0; i < int'(N); i++) out_d[i] = (state_d == StOn) && (int'(zone_d) == i);
        az_d   = (state_d == StOn) ? zone_d + SEL_W'(1) : '0;
        done_d = (state_d == StFin);
    end

    always_ff @(posedge clk_i or posedge rst_int) begin
        if (rst_int) begin
            state_q      <= StIdle;
            zone_q       <= '0;
            gtgt_q       <= '0;
            gap_q        <= '0;
            dwell_left_q <= '0;
            dwell_lat_q  <= '0;
            mask_q       <= '0;
            busy_q       <= 1'b0;
            out_q        <= '0;
            az_q         <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            zone_q       <= zone_d;
            gtgt_q       <= gtgt_d;
            gap_q        <= gap_d;
            dwell_left_q <= dwell_left_d;
            dwell_lat_q  <= dwell_lat_d;
            mask_q       <= mask_d;
            busy_q       <= busy_d;
            out_q        <= out_d;
            az_q         <= az_d;
            done_q       <= done_d;
        end
    end

    assign out_o         = out_q;
    assign active_zone_o = az_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule

// File: tb/tb_zone_demux_seq.sv
// Testbench for zone_demux_seq: manual vector table, hand-written auto sequences and a
// randomized run against a behavioural model.
module tb_zone_demux_seq;

    localparam int N       = 7;
    localparam int SEL_W   = 3;
    localparam int DWELL_W = 16;
    localparam int GAP     = 2;

    logic               clk;
    logic               reset_r;
    logic               in_r;
    logic               mode_r;
    logic [SEL_W-1:0]   sel_r;
    logic               start_r;
    logic [DWELL_W-1:0] dwell_r;
    logic [N-1:0]       mask_r;
    logic [N-1:0]       out_w;
    logic [SEL_W-1:0]   az_w;
    logic               busy_w;
    logic               done_w;

    int checks = 0;
    int errors = 0;

    zone_demux_seq #(
        .N       (N),
        .SEL_W   (SEL_W),
        .DWELL_W (DWELL_W),
        .GAP     (GAP)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset_r),
        .in_i          (in_r),
        .mode_i        (mode_r),
        .sel_i         (sel_r),
        .start_i       (start_r),
        .dwell_i       (dwell_r),
        .zone_mask_i   (mask_r),
        .out_o         (out_w),
        .active_zone_o (az_w),
        .busy_o        (busy_w),
        .done_o        (done_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             in_v;
        logic             mode_v;
        logic [SEL_W-1:0] sel_v;
        logic [N-1:0]     eout;
        logic [SEL_W-1:0] eaz;
    } vec_t;

    vec_t tbl [16];

    // Behavioural model state: open zone code, gap bookkeeping, per-zone remaining dwell.
    int m_open, m_pend, m_closed;
    bit m_auto, m_gapping, m_fin;
    int m_left [N];
    bit m_mask [N];

    task automatic chk(input string name, input logic [N-1:0] eo, input logic [SEL_W-1:0] eaz,
                       input logic eb, input logic ed);
        checks++;
        if ({out_w, az_w, busy_w, done_w} !== {eo, eaz, eb, ed}) begin
            errors++;
            $display("FAIL %s @%0t: got out=%b az=%0d busy=%b done=%b, expected out=%b az=%0d busy=%b done=%b",
                     name, $time, out_w, az_w, busy_w, done_w, eo, eaz, eb, ed);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_r = 1'b1;
        in_r    = 1'b0;
        mode_r  = 1'b0;
        sel_r   = '0;
        start_r = 1'b0;
        dwell_r = '0;
        mask_r  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_r = 1'b0;
        repeat (4) step();
    endtask

    task automatic start_seq(input int dw, input logic [N-1:0] mk);
        mode_r  = 1'b1;
        in_r    = 1'b1;
        dwell_r = DWELL_W'(dw);
        mask_r  = mk;
        start_r = 1'b1;
        step();
        start_r = 1'b0;
    endtask

    task automatic m_reset();
        m_open = 0; m_pend = 0; m_closed = 0;
        m_auto = 0; m_gapping = 0; m_fin = 0;
        for (int i = 0; i < N; i++) begin
            m_left[i] = 0;
            m_mask[i] = 0;
        end
    endtask

    // Decide what the valves show after this clock edge, from the rules of operation.
    task automatic m_edge();
        int t, first, nxt;
        bit idle, fin_prev;
        t = (in_r && sel_r >= 1 && int'(sel_r) <= N) ? int'(sel_r) : 0;
        fin_prev = m_fin;
        m_fin = 0;
        if (!mode_r) begin
            if (m_auto) begin
                m_auto = 0; m_open = 0; m_gapping = 1; m_pend = t; m_closed = 1;
            end else if (m_open != 0) begin
                if (t == 0) m_open = 0;
                else if (t != m_open) begin
                    m_open = 0; m_gapping = 1; m_pend = t; m_closed = 1;
                end
            end else if (m_gapping) begin
                if (t == 0) m_gapping = 0;
                else if (t != m_pend) begin
                    m_pend = t; m_closed = 1;
                end else if (m_closed >= GAP) begin
                    m_open = t; m_gapping = 0;
                end else m_closed++;
            end else if (t != 0) m_open = t;
        end else if (!m_auto) begin
            idle = (m_open == 0) && !m_gapping && !fin_prev;
            m_open = 0;
            m_gapping = 0;
            if (idle && start_r && in_r) begin
                first = 0;
                for (int i = N - 1; i >= 0; i--) begin
                    m_mask[i] = mask_r[i];
                    m_left[i] = (dwell_r == 0) ? 1 : int'(dwell_r);
                    if (mask_r[i]) first = i + 1;
                end
                if (first != 0) begin
                    m_auto = 1; m_open = first;
                end else m_fin = 1;
            end
        end else if (m_open != 0) begin
            m_left[m_open-1]--;
            if (m_left[m_open-1] == 0) begin
                nxt = 0;
                for (int i = N - 1; i >= m_open; i--) if (m_mask[i]) nxt = i + 1;
                m_open = 0;
                if (nxt != 0) begin
                    m_gapping = 1; m_pend = nxt; m_closed = 1;
                end else begin
                    m_auto = 0; m_fin = 1;
                end
            end else if (!in_r) begin
                m_pend = m_open; m_open = 0; m_gapping = 1; m_closed = 0;
            end
        end else if (in_r) begin
            if (m_closed >= GAP) begin
                m_open = m_pend; m_gapping = 0;
            end else m_closed++;
        end
    endtask

    task automatic chk_model(input string name);
        logic [N-1:0] eo;
        eo = '0;
        if (m_open != 0) eo[m_open-1] = 1'b1;
        chk(name, eo, SEL_W'(m_open), m_auto, m_fin);
    endtask

    initial begin
        int busy_cnt;
        reset_r = 1'b1;
        in_r = 1'b0; mode_r = 1'b0; sel_r = '0; start_r = 1'b0; dwell_r = '0; mask_r = '0;
        #3;
        chk("reset_state", '0, '0, 1'b0, 1'b0);
        do_reset();
        chk("after_release", '0, '0, 1'b0, 1'b0);

        // Manual mode: open, close, break-before-make, gap restart, mode switch.
        tbl[0]  = '{1'b1, 1'b0, 3'd3, 7'b0000100, 3'd3};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 7'b0000000, 3'd0};
        tbl[2]  = '{1'b1, 1'b0, 3'd1, 7'b0000001, 3'd1};
        tbl[3]  = '{1'b1, 1'b0, 3'd5, 7'b0000000, 3'd0};
        tbl[4]  = '{1'b1, 1'b0, 3'd5, 7'b0000000, 3'd0};
        tbl[5]  = '{1'b1, 1'b0, 3'd5, 7'b0010000, 3'd5};
        tbl[6]  = '{1'b1, 1'b0, 3'd7, 7'b0000000, 3'd0};
        tbl[7]  = '{1'b1, 1'b0, 3'd2, 7'b0000000, 3'd0};
        tbl[8]  = '{1'b1, 1'b0, 3'd2, 7'b0000000, 3'd0};
        tbl[9]  = '{1'b1, 1'b0, 3'd2, 7'b0000010, 3'd2};
        tbl[10] = '{1'b0, 1'b0, 3'd6, 7'b0000000, 3'd0};
        tbl[11] = '{1'b1, 1'b0, 3'd6, 7'b0100000, 3'd6};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 7'b0000000, 3'd0};
        tbl[13] = '{1'b1, 1'b0, 3'd7, 7'b1000000, 3'd7};
        tbl[14] = '{1'b1, 1'b1, 3'd7, 7'b0000000, 3'd0};
        tbl[15] = '{1'b1, 1'b1, 3'd7, 7'b0000000, 3'd0};
        for (int v = 0; v < 16; v++) begin
            in_r   = tbl[v].in_v;
            mode_r = tbl[v].mode_v;
            sel_r  = tbl[v].sel_v;
            step();
            chk($sformatf("manual_vec%0d", v), tbl[v].eout, tbl[v].eaz, 1'b0, 1'b0);
        end

        // Full auto sequence over alternate zones.
        do_reset();
        start_seq(4, 7'b1010101);
        busy_cnt = 0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                chk("t3_on", N'(1 << (2 * k)), SEL_W'(2 * k + 1), 1'b1, 1'b0);
                busy_cnt += int'(busy_w);
                step();
            end
            if (k < 3) begin
                for (int j = 0; j < 2; j++) begin
                    chk("t3_gap", '0, '0, 1'b1, 1'b0);
                    busy_cnt += int'(busy_w);
                    step();
                end
            end
        end
        chk("t3_done", '0, '0, 1'b0, 1'b1);
        busy_cnt += int'(busy_w);
        step();
        chk("t3_idle", '0, '0, 1'b0, 1'b0);
        chk_int("t3_busy_cycles", busy_cnt, 22);

        // Pause on in=0 mid-dwell, resume after gap with remaining dwell.
        do_reset();
        start_seq(3, 7'b0000110);
        chk("t4_first", 7'b0000010, 3'd2, 1'b1, 1'b0);
        in_r = 1'b0;
        repeat (5) begin step(); chk("t4_paused", '0, '0, 1'b1, 1'b0); end
        in_r = 1'b1;
        repeat (2) begin step(); chk("t4_resume_gap", '0, '0, 1'b1, 1'b0); end
        repeat (2) begin step(); chk("t4_remaining", 7'b0000010, 3'd2, 1'b1, 1'b0); end
        repeat (2) begin step(); chk("t4_gap", '0, '0, 1'b1, 1'b0); end
        repeat (3) begin step(); chk("t4_zone3", 7'b0000100, 3'd3, 1'b1, 1'b0); end
        step();
        chk("t4_done", '0, '0, 1'b0, 1'b1);

        // Empty mask and zero dwell.
        do_reset();
        start_seq(5, 7'b0000000);
        chk("t5_empty_done", '0, '0, 1'b0, 1'b1);
        step();
        chk("t5_empty_after", '0, '0, 1'b0, 1'b0);
        start_seq(0, 7'b1000001);
        chk("t5_dw0_z1", 7'b0000001, 3'd1, 1'b1, 1'b0);
        step(); chk("t5_gap1", '0, '0, 1'b1, 1'b0);
        step(); chk("t5_gap2", '0, '0, 1'b1, 1'b0);
        step(); chk("t5_dw0_z7", 7'b1000000, 3'd7, 1'b1, 1'b0);
        step(); chk("t5_done", '0, '0, 1'b0, 1'b1);

        // Asynchronous reset mid-dwell.
        do_reset();
        start_seq(5, 7'b0001000);
        chk("t6_on", 7'b0001000, 3'd4, 1'b1, 1'b0);
        step();
        #2;
        reset_r = 1'b1;
        #1;
        chk("t6_async_reset", '0, '0, 1'b0, 1'b0);
        step();
        chk("t6_held", '0, '0, 1'b0, 1'b0);
        reset_r = 1'b0;
        in_r = 1'b0;
        repeat (4) step();
        chk("t6_released", '0, '0, 1'b0, 1'b0);

        // Abort by leaving auto mode: gap, then the manual target, never done.
        do_reset();
        start_seq(6, 7'b0000011);
        step();
        step();
        chk("t6_pre_abort", 7'b0000001, 3'd1, 1'b1, 1'b0);
        mode_r = 1'b0;
        sel_r  = 3'd3;
        step(); chk("t6_abort", '0, '0, 1'b0, 1'b0);
        step(); chk("t6_abort_gap", '0, '0, 1'b0, 1'b0);
        repeat (3) begin step(); chk("t6_manual", 7'b0000100, 3'd3, 1'b0, 1'b0); end

        // Randomized run against the behavioural model.
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(39) == 0) mode_r = ~mode_r;
            in_r = ($urandom_range(7) != 0);
            if ($urandom_range(3) == 0) sel_r = SEL_W'($urandom_range(7));
            start_r = ($urandom_range(5) == 0);
            dwell_r = DWELL_W'($urandom_range(5));
            mask_r  = ($urandom_range(9) == 0) ? '0 : N'($urandom);
            @(posedge clk);
            m_edge();
            #1;
            chk_model("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
